// File: rtl/regfile_dump_reader.sv
// Read-side sequencer that walks a wrapping address window of a register file and streams words out over valid/ready.
// Optional feature macro: REGFILE_DUMP_PARITY_EN (adds PARITY_O and BEAT_LAST_O).
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module regfile_dump_reader #(
    parameter int unsigned REGFILE_SIZE       = 128,
    parameter int unsigned REGFILE_ADDR_WIDTH = 7
) (
    input  logic                          CLK_I,
    input  logic                          RST_N_I,
    input  logic                          EN_I,
    input  logic                          START_I,
    input  logic [REGFILE_ADDR_WIDTH-1:0] BASE_ADDR_I,
    input  logic [REGFILE_ADDR_WIDTH:0]   COUNT_I,
    output logic [REGFILE_ADDR_WIDTH-1:0] RF_RD_ADDR_O,
    input  logic [`DATA_WIDTH-1:0]        RF_RD_DATA_I,
    output logic [`DATA_WIDTH-1:0]        DATA_O,
    output logic [REGFILE_ADDR_WIDTH-1:0] ADDR_O,
    output logic                          VALID_O,
    input  logic                          READY_I,
    output logic                          BUSY_O,
    output logic                          DONE_O
`ifdef REGFILE_DUMP_PARITY_EN
    ,
    output logic                          PARITY_O,
    output logic                          BEAT_LAST_O
`endif
);

    localparam int unsigned AW = REGFILE_ADDR_WIDTH;
    localparam int unsigned CW = REGFILE_ADDR_WIDTH + 1;
    localparam int unsigned DW = `DATA_WIDTH;

    localparam logic [AW-1:0] LAST_ADDR = AW'(REGFILE_SIZE - 1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_READ = 1'b1;

    logic [0:0]    state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [CW-1:0] rem_q, rem_d;
    logic [DW-1:0] data_q, data_d;
    logic [AW-1:0] out_addr_q, out_addr_d;
    logic          valid_q, valid_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          load_c;
`ifdef REGFILE_DUMP_PARITY_EN
    logic          parity_q, parity_d;
    logic          last_q, last_d;
`endif

    // A new word may enter the output register when it is empty or being drained this cycle.
    assign load_c = (state_q == ST_READ) && (rem_q != '0) && (!valid_q || READY_I);

    // State and datapath registers; EN_I low freezes everything, including DONE_O.
    always_ff @(posedge CLK_I or negedge RST_N_I) begin
        if (!RST_N_I) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            rem_q      <= '0;
            data_q     <= '0;
            out_addr_q <= '0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef REGFILE_DUMP_PARITY_EN
            parity_q   <= 1'b0;
            last_q     <= 1'b0;
`endif
        end else if (EN_I) begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            rem_q      <= rem_d;
            data_q     <= data_d;
            out_addr_q <= out_addr_d;
            valid_q    <= valid_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
`ifdef REGFILE_DUMP_PARITY_EN
            parity_q   <= parity_d;
            last_q     <= last_d;
`endif
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        rem_d      = rem_q;
        data_d     = data_q;
        out_addr_d = out_addr_q;
        valid_d    = valid_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
`ifdef REGFILE_DUMP_PARITY_EN
        parity_d   = parity_q;
        last_d     = last_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (START_I) begin
                    if (COUNT_I != '0) begin
                        state_d = ST_READ;
                        addr_d  = BASE_ADDR_I;
                        rem_d   = COUNT_I;
                        busy_d  = 1'b1;
                    end else begin
                        done_d  = 1'b1;
                    end
                end
            end

            ST_READ: begin
                if (load_c) begin
                    data_d     = RF_RD_DATA_I;
                    out_addr_d = addr_q;
                    valid_d    = 1'b1;
                    addr_d     = (addr_q == LAST_ADDR) ? '0 : addr_q + AW'(1);
                    rem_d      = rem_q - CW'(1);
`ifdef REGFILE_DUMP_PARITY_EN
                    parity_d   = ^RF_RD_DATA_I;
                    last_d     = (rem_q == CW'(1));
`endif
                end else if ((rem_q == '0) && (!valid_q || READY_I)) begin
                    // Final beat drained: close the dump.
                    valid_d = 1'b0;
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
`ifdef REGFILE_DUMP_PARITY_EN
                    last_d  = 1'b0;
`endif
                end
            end

            default: begin
                state_d = ST_IDLE;
                valid_d = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign RF_RD_ADDR_O = addr_q;
    assign DATA_O       = data_q;
    assign ADDR_O       = out_addr_q;
    assign VALID_O      = valid_q;
    assign BUSY_O       = busy_q;
    assign DONE_O       = done_q;
`ifdef REGFILE_DUMP_PARITY_EN
    assign PARITY_O     = parity_q;
    assign BEAT_LAST_O  = last_q;
`endif

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Self-checking bench for regfile_dump_reader: scoreboard of expected (addr, data) beats plus per-scenario timing checks.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module tb_regfile_dump_reader;

    localparam int unsigned AW   = 7;
    localparam int unsigned SIZE = 128;
    localparam int unsigned DW   = `DATA_WIDTH;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } beat_t;

    logic          clk;
    logic          rst_n;
    logic          en;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW:0]   cnt_in;
    logic [AW-1:0] rf_rd_addr;
    logic [DW-1:0] rf_rd_data;
    logic [DW-1:0] data;
    logic [AW-1:0] addr;
    logic          valid;
    logic          ready;
    logic          busy;
    logic          done;
`ifdef REGFILE_DUMP_PARITY_EN
    logic          parity;
    logic          beat_last;
`endif

    logic [DW-1:0] rf [SIZE];
    beat_t         exp_q[$];
    beat_t         mon_exp;
    int            vectors     = 0;
    int            miscompares = 0;
    int            beats_seen  = 0;

    assign rf_rd_data = rf[rf_rd_addr];

    regfile_dump_reader #(
        .REGFILE_SIZE       (SIZE),
        .REGFILE_ADDR_WIDTH (AW)
    ) dut (
        .CLK_I        (clk),
        .RST_N_I      (rst_n),
        .EN_I         (en),
        .START_I      (start),
        .BASE_ADDR_I  (base_addr),
        .COUNT_I      (cnt_in),
        .RF_RD_ADDR_O (rf_rd_addr),
        .RF_RD_DATA_I (rf_rd_data),
        .DATA_O       (data),
        .ADDR_O       (addr),
        .VALID_O      (valid),
        .READY_I      (ready),
        .BUSY_O       (busy),
        .DONE_O       (done)
`ifdef REGFILE_DUMP_PARITY_EN
        ,
        .PARITY_O     (parity),
        .BEAT_LAST_O  (beat_last)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard: every beat that will handshake on the coming edge is checked against the queue.
    always @(negedge clk) begin
        if (rst_n && en && valid && ready) begin
            beats_seen++;
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL beat_unexpected got addr=%0d data=%h", addr, data);
            end else begin
                mon_exp = exp_q.pop_front();
                if ({addr, data} !== mon_exp) begin
                    miscompares++;
                    $display("FAIL beat got addr=%0d data=%h want addr=%0d data=%h",
                             addr, data, mon_exp.addr, mon_exp.data);
                end
            end
        end
    end

    task automatic push_window(input int unsigned b, input int unsigned n);
        for (int unsigned k = 0; k < n; k++) begin
            int unsigned a;
            a = (b + k) % SIZE;
            exp_q.push_back('{addr: AW'(a), data: rf[a]});
        end
    endtask

    // Raise START for one edge; the caller lowers it on its first loop iteration.
    task automatic start_dump(input logic [AW-1:0] b, input logic [AW:0] n);
        @(posedge clk); #1;
        start     = 1'b1;
        base_addr = b;
        cnt_in    = n;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        vectors++;
        if ({valid, busy, done} !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_flags got=%b want=000", {valid, busy, done});
        end
        vectors++;
        if ({data, addr, rf_rd_addr} !== '0) begin
            miscompares++;
            $display("FAIL reset_data got data=%h addr=%0d rdaddr=%0d want 0", data, addr, rf_rd_addr);
        end
`ifdef REGFILE_DUMP_PARITY_EN
        vectors++;
        if ({parity, beat_last} !== 2'b00) begin
            miscompares++;
            $display("FAIL reset_parity got=%b want=00", {parity, beat_last});
        end
`endif
        @(posedge clk); #2;
        rst_n = 1'b1;
        @(negedge clk);
        vectors++;
        if ({valid, busy, done, addr} !== '0) begin
            miscompares++;
            $display("FAIL post_reset_idle got v=%b b=%b d=%b a=%0d want 0", valid, busy, done, addr);
        end
    endtask

    task automatic test_full_rate();
        int busy_cycles = 0, valid_cycles = 0, done_cnt = 0;
        int first_valid = -1, done_at = -1, b0;
        for (int k = 0; k < 4; k++) rf[k] = DW'(32'hA0 + k);
        ready = 1'b1;
        b0 = beats_seen;
        push_window(0, 4);
        start_dump(AW'(0), (AW+1)'(4));
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (i == 0) start = 1'b0;
            @(negedge clk);
            if (busy) busy_cycles++;
            if (valid) begin
                valid_cycles++;
                if (first_valid < 0) first_valid = i;
            end
            if (done) begin
                done_cnt++;
                if (done_at < 0) done_at = i;
            end
        end
        vectors++;
        if (first_valid !== 1) begin
            miscompares++; $display("FAIL full_first_valid got=%0d want=1", first_valid);
        end
        vectors++;
        if (valid_cycles !== 4) begin
            miscompares++; $display("FAIL full_valid_cycles got=%0d want=4", valid_cycles);
        end
        vectors++;
        if (busy_cycles !== 5) begin
            miscompares++; $display("FAIL full_busy_cycles got=%0d want=5", busy_cycles);
        end
        vectors++;
        if ((done_at !== 5) || (done_cnt !== 1)) begin
            miscompares++; $display("FAIL full_done got at=%0d n=%0d want at=5 n=1", done_at, done_cnt);
        end
        vectors++;
        if ((beats_seen - b0 !== 4) || (exp_q.size() !== 0)) begin
            miscompares++;
            $display("FAIL full_beats got=%0d left=%0d want 4 and 0", beats_seen - b0, exp_q.size());
        end
    endtask

    task automatic test_wrap();
        logic [AW-1:0] seq [4];
        int nv = 0, b0;
        logic [4*AW-1:0] got, want;
        ready = 1'b1;
        b0 = beats_seen;
        push_window(126, 4);
        start_dump(AW'(126), (AW+1)'(4));
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (i == 0) start = 1'b0;
            @(negedge clk);
            if (valid && nv < 4) begin
                seq[nv] = addr;
                nv++;
            end
        end
        got  = {seq[0], seq[1], seq[2], seq[3]};
        want = {AW'(126), AW'(127), AW'(0), AW'(1)};
        vectors++;
        if ((nv !== 4) || (got !== want)) begin
            miscompares++;
            $display("FAIL wrap_seq got n=%0d %0d,%0d,%0d,%0d want 126,127,0,1",
                     nv, seq[0], seq[1], seq[2], seq[3]);
        end
        vectors++;
        if ((beats_seen - b0 !== 4) || (exp_q.size() !== 0)) begin
            miscompares++; $display("FAIL wrap_beats got=%0d want=4", beats_seen - b0);
        end
    endtask

    task automatic test_backpressure();
        int seen = -1, stable = 1, done_at = -1, b0;
        logic [DW-1:0] d0;
        logic [AW-1:0] a0;
        logic [AW-1:0] a1 = '0, a2 = '0;
        ready = 1'b0;
        b0 = beats_seen;
        push_window(10, 3);
        start_dump(AW'(10), (AW+1)'(3));
        for (int i = 0; i < 5 && seen < 0; i++) begin
            @(posedge clk); #1;
            if (i == 0) start = 1'b0;
            @(negedge clk);
            if (valid) seen = i;
        end
        vectors++;
        if (seen !== 1) begin
            miscompares++; $display("FAIL bp_first_valid got=%0d want=1", seen);
        end
        d0 = data;
        a0 = addr;
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk); #1;
            if (k == 3) ready = 1'b1;
            @(negedge clk);
            if (valid && data === d0 && addr === a0) stable++;
        end
        vectors++;
        if ((stable !== 4) || (a0 !== AW'(10)) || (d0 !== rf[10])) begin
            miscompares++;
            $display("FAIL bp_stall got stable=%0d addr=%0d want 4 cycles at addr 10", stable, a0);
        end
        for (int j = 1; j <= 6; j++) begin
            @(posedge clk); #1;
            @(negedge clk);
            if (j == 1 && valid) a1 = addr;
            if (j == 2 && valid) a2 = addr;
            if (done && done_at < 0) done_at = j;
        end
        vectors++;
        if ({a1, a2} !== {AW'(11), AW'(12)} || done_at !== 3) begin
            miscompares++;
            $display("FAIL bp_b2b got a1=%0d a2=%0d done_at=%0d want 11 12 3", a1, a2, done_at);
        end
        vectors++;
        if ((beats_seen - b0 !== 3) || (exp_q.size() !== 0)) begin
            miscompares++; $display("FAIL bp_handshakes got=%0d want=3", beats_seen - b0);
        end
    endtask

    task automatic test_zero_busy();
        int done_at = -1, done_cnt = 0, valid_any = 0, busy_any = 0, b0;
        ready = 1'b1;
        start_dump(AW'(5), '0);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (i == 0) start = 1'b0;
            @(negedge clk);
            if (valid) valid_any++;
            if (busy) busy_any++;
            if (done) begin
                done_cnt++;
                if (done_at < 0) done_at = i;
            end
        end
        vectors++;
        if ((done_at !== 0) || (done_cnt !== 1) || (valid_any !== 0) || (busy_any !== 0)) begin
            miscompares++;
            $display("FAIL zero_count got done_at=%0d n=%0d valid=%0d busy=%0d want 0 1 0 0",
                     done_at, done_cnt, valid_any, busy_any);
        end
        done_cnt = 0;
        b0 = beats_seen;
        push_window(20, 2);
        start_dump(AW'(20), (AW+1)'(2));
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (i == 0) start = 1'b0;
            if (i == 1) begin
                start     = 1'b1;
                base_addr = AW'(50);
                cnt_in    = (AW+1)'(5);
            end
            if (i == 2) start = 1'b0;
            @(negedge clk);
            if (done) done_cnt++;
        end
        vectors++;
        if ((beats_seen - b0 !== 2) || (done_cnt !== 1) || (exp_q.size() !== 0) || busy) begin
            miscompares++;
            $display("FAIL busy_start got beats=%0d done=%0d busy=%b want 2 1 0",
                     beats_seen - b0, done_cnt, busy);
        end
    endtask

    task automatic test_en_freeze();
        int frozen = 0, done_at = -1, b0;
        logic [DW-1:0] sd = '0;
        logic [AW-1:0] sa = '0;
        logic          sv = 1'b0, sb = 1'b0;
        ready = 1'b1;
        b0 = beats_seen;
        push_window(30, 4);
        start_dump(AW'(30), (AW+1)'(4));
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (i == 0) start = 1'b0;
            if (i == 3) en = 1'b0;
            if (i == 5) en = 1'b1;
            @(negedge clk);
            if (i == 3) begin
                sd = data; sa = addr; sv = valid; sb = busy;
            end
            if ((i == 4 || i == 5) && {data, addr, valid, busy} === {sd, sa, sv, sb}) frozen++;
            if (done && done_at < 0) done_at = i;
        end
        vectors++;
        if ((frozen !== 2) || (sa !== AW'(32)) || !sv || !sb) begin
            miscompares++;
            $display("FAIL en_freeze got frozen=%0d addr=%0d v=%b b=%b want 2 32 1 1", frozen, sa, sv, sb);
        end
        vectors++;
        if ((done_at !== 7) || (beats_seen - b0 !== 4) || (exp_q.size() !== 0)) begin
            miscompares++;
            $display("FAIL en_resume got done_at=%0d beats=%0d want 7 4", done_at, beats_seen - b0);
        end
    endtask

    task automatic test_reset_mid();
        int done_cnt = 0, b0;
        ready = 1'b1;
        push_window(40, 6);
        start_dump(AW'(40), (AW+1)'(6));
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (i == 0) start = 1'b0;
            @(negedge clk);
        end
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({valid, busy, done, data, addr, rf_rd_addr} !== '0) begin
            miscompares++;
            $display("FAIL reset_async got v=%b b=%b data=%h addr=%0d want all 0", valid, busy, data, addr);
        end
        exp_q.delete();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
        @(posedge clk); #2;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (done || busy || valid) done_cnt++;
        end
        vectors++;
        if (done_cnt !== 0) begin
            miscompares++; $display("FAIL reset_no_done got=%0d want=0", done_cnt);
        end
        b0 = beats_seen;
        push_window(60, 2);
        start_dump(AW'(60), (AW+1)'(2));
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (i == 0) start = 1'b0;
            @(negedge clk);
            if (done) done_cnt++;
        end
        vectors++;
        if ((beats_seen - b0 !== 2) || (done_cnt !== 1) || (exp_q.size() !== 0)) begin
            miscompares++;
            $display("FAIL reset_restart got beats=%0d done=%0d want 2 1", beats_seen - b0, done_cnt);
        end
    endtask

`ifdef REGFILE_DUMP_PARITY_EN
    task automatic test_parity();
        logic [1:0] par = '0, lst = '0;
        int nv = 0;
        rf[70] = DW'(1);
        rf[71] = DW'(3);
        ready = 1'b1;
        push_window(70, 2);
        start_dump(AW'(70), (AW+1)'(2));
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (i == 0) start = 1'b0;
            @(negedge clk);
            if (valid && nv < 2) begin
                par[nv] = parity;
                lst[nv] = beat_last;
                nv++;
            end
        end
        vectors++;
        if ((nv !== 2) || (par !== 2'b01)) begin
            miscompares++; $display("FAIL parity got n=%0d p1=%b p0=%b want p0=1 p1=0", nv, par[1], par[0]);
        end
        vectors++;
        if (lst !== 2'b10) begin
            miscompares++; $display("FAIL beat_last got l1=%b l0=%b want l0=0 l1=1", lst[1], lst[0]);
        end
    endtask
`endif

    initial begin
        rst_n     = 1'b0;
        en        = 1'b1;
        start     = 1'b0;
        base_addr = '0;
        cnt_in    = '0;
        ready     = 1'b0;
        for (int k = 0; k < int'(SIZE); k++) rf[k] = DW'($urandom);
        test_reset();
        test_full_rate();
        test_wrap();
        test_backpressure();
        test_zero_busy();
        test_en_freeze();
        test_reset_mid();
`ifdef REGFILE_DUMP_PARITY_EN
        test_parity();
`endif
        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/regfile_dump_reader.md
Name: regfile_dump_reader

Overview:
- Read-side sequencer for the autogenerated register file.
- On a start command, it walks a contiguous, wrapping address window over one register-file read port.
- Each word read is captured into an output register and streamed out over a valid/ready interface, tagged with its address.
- Used for debug readout and context save of the CGRA register files; the register file's write port is unaffected.

Parameters:
- REGFILE_SIZE, 128, number of entries in the attached register file; addresses wrap modulo this value.
- REGFILE_ADDR_WIDTH, 7, width of register-file addresses; REGFILE_SIZE <= 2^REGFILE_ADDR_WIDTH.

Ports:
- CLK_I  in  1  single clock, rising edge.
- RST_N_I  in  1  asynchronous, active-low reset.
- EN_I  in  1  global enable; when low, all registers hold their values.
- START_I  in  1  start request; sampled only in IDLE with EN_I high.
- BASE_ADDR_I  in  REGFILE_ADDR_WIDTH  first address; sampled with START_I.
- COUNT_I  in  REGFILE_ADDR_WIDTH+1  number of words to read; sampled with START_I.
- RF_RD_ADDR_O  out  REGFILE_ADDR_WIDTH  address to the register-file read port.
- RF_RD_DATA_I  in  `DATA_WIDTH  combinational read data returned for RF_RD_ADDR_O.
- DATA_O  out  `DATA_WIDTH  streamed word.
- ADDR_O  out  REGFILE_ADDR_WIDTH  register-file address of DATA_O.
- VALID_O  out  1  DATA_O and ADDR_O are valid.
- READY_I  in  1  consumer accepts the beat when VALID_O and READY_I are both high.
- BUSY_O  out  1  a dump is in progress.
- DONE_O  out  1  one-cycle pulse when a dump completes.

Behaviour:
- Reset values: all outputs 0, state IDLE, address and remaining-count registers 0.
- When EN_I is low, nothing advances: state, counters and output register all hold. DONE_O holds its value.
- States:
  - IDLE -> READ when START_I is high and COUNT_I != 0. Latch addr = BASE_ADDR_I, rem = COUNT_I; BUSY_O = 1 from the next cycle.
  - IDLE -> IDLE when START_I is high and COUNT_I == 0. DONE_O pulses on the next cycle, BUSY_O stays 0, no beats are issued.
  - READ: RF_RD_ADDR_O = addr.
    - Load condition: rem != 0 && (!VALID_O || READY_I).
    - On load: DATA_O <= RF_RD_DATA_I, ADDR_O <= addr, VALID_O <= 1, addr <= (addr == REGFILE_SIZE-1) ? 0 : addr+1, rem <= rem-1.
    - On a handshake with no load (rem == 0): VALID_O <= 0.
    - When rem == 0 and the last beat handshakes: -> IDLE, DONE_O = 1 for one cycle, BUSY_O = 0 on the same edge.
- Throughput: 1 word/cycle while READY_I is held high. First VALID_O appears 1 cycle after the START-accept edge.
- Stall: while VALID_O && !READY_I, DATA_O, ADDR_O and VALID_O are stable and addr does not advance.
- START_I while BUSY_O is high: ignored.
- COUNT_I > REGFILE_SIZE: legal; the walk wraps and repeats addresses.
- Coherency: each word is captured at its load edge, with no snapshot semantics. A write to the register file before an address is loaded is visible in the dump; a write after the load is not.
- Reset mid-dump: immediate return to the reset state. A partially streamed dump is abandoned and no DONE_O is issued.
- RF_RD_ADDR_O in IDLE: equals the last addr value. The register-file read port is a don't-care in that state.

Optional Feature:
- Macro: REGFILE_DUMP_PARITY_EN.
- Defined:
  - Adds output PARITY_O (1 bit, reset 0), the even parity (XOR reduction) of RF_RD_DATA_I, registered with DATA_O on every load and held under stall.
  - Adds output BEAT_LAST_O (1 bit, reset 0), high on the final beat of a dump.
- Undefined: neither port exists; all other behaviour is identical.

Test Plan:
- Full-rate dump:
  - Stimulus: preload regs 0..3 with 0xA0..0xA3; START_I with BASE=0, COUNT=4; READY_I held 1.
  - Response: beats (0,0xA0), (1,0xA1), (2,0xA2), (3,0xA3) on 4 consecutive cycles; DONE_O pulses 1 cycle after the last beat; BUSY_O high for 5 cycles.
- Wrap-around:
  - Stimulus: BASE=126, COUNT=4, REGFILE_SIZE=128.
  - Response: ADDR_O sequence 126, 127, 0, 1.
- Backpressure:
  - Stimulus: BASE=10, COUNT=3; READY_I low for 3 cycles after the first VALID_O.
  - Response: ADDR_O=10 with its data held stable for 4 cycles; afterwards 11 and 12 follow back-to-back; exactly 3 handshakes total.
- Zero count and busy start:
  - Stimulus: COUNT=0, then START_I pulses during a COUNT=2 dump.
  - Response: single DONE_O pulse with no VALID_O for the COUNT=0 start; the mid-dump START_I is ignored; only 2 beats issued.
- EN_I freeze and reset:
  - Stimulus: drop EN_I for 2 cycles mid-dump, then assert RST_N_I low mid-dump.
  - Response: outputs are frozen while EN_I is low and the dump resumes without loss; on reset all outputs are 0 asynchronously, no DONE_O is issued, and a new START_I works.
- Parity (REGFILE_DUMP_PARITY_EN defined):
  - Stimulus: dump words 0x1 and 0x3.
  - Response: PARITY_O = 1 then 0; BEAT_LAST_O high only on the second beat.
